// File: rtl/bht_update_queue_pkg.sv
// rtl/bht_update_queue_pkg.sv - shared BHT types and the 2-bit counter transition function
package bht_update_queue_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic       valid;
    virt_t      pc;
    logic       taken;
    logic [1:0] counter;
  } bht_update_t;

  typedef struct packed {
    virt_t      pc;
    logic       taken;
    logic [1:0] counter;
  } resolve_entry_t;

  // Saturating transitions shared with the bht read/write path.
  function automatic logic [1:0] bht_next_counter(input logic [1:0] counter, input logic taken);
    logic [1:0] next;
    if (taken) begin
      next = (counter == 2'b00) ? 2'b01 : 2'b11;
    end else begin
      next = (counter == 2'b11) ? 2'b10 : 2'b00;
    end
    return next;
  endfunction

endpackage

// File: rtl/bht_update_queue_fifo.sv
// rtl/bht_update_queue_fifo.sv - sync_fifo: power-of-two synchronous FIFO without fall-through
module sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type dtype = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  dtype din,
  input  logic pop,
  output dtype dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  dtype          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - buffers resolved branches and issues one BHT update per cycle
// Optional counter forwarding across same-entry updates: BHT_COUNTER_FWD_EN.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int SIZE      = 4096,
  parameter int DEPTH     = 8,
  parameter int FWD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid,
  input  virt_t       resolve_pc,
  input  logic        resolve_taken,
  input  logic [1:0]  resolve_counter,
  output logic        resolve_ready,
  input  logic        drain_en,
  output bht_update_t update
);

  localparam int KHI = $clog2(SIZE / 2) + 2;
  localparam int KW  = KHI - 1;

  resolve_entry_t din;
  resolve_entry_t head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [1:0]     issue_counter;

  assign din           = '{pc: resolve_pc, taken: resolve_taken, counter: resolve_counter};
  assign push          = resolve_valid & ~full;
  assign pop           = drain_en & ~empty;
  assign resolve_ready = ~full;

  sync_fifo #(
    .DEPTH (DEPTH),
    .dtype (resolve_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef BHT_COUNTER_FWD_EN
  logic [KW-1:0] head_key;
  logic          fwd_valid [FWD_DEPTH];
  logic [KW-1:0] fwd_key   [FWD_DEPTH];
  logic [1:0]    fwd_ctr   [FWD_DEPTH];

  assign head_key = head.pc[KHI:2];

  // Scan oldest to newest so the lowest-index (newest) match wins.
  always_comb begin
    issue_counter = head.counter;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_key[i] == head_key)) begin
        issue_counter = fwd_ctr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        fwd_valid[i] <= 1'b0;
        fwd_key[i]   <= '0;
        fwd_ctr[i]   <= 2'b00;
      end
    end else if (pop) begin
      for (int i = 1; i < FWD_DEPTH; i++) begin
        fwd_valid[i] <= fwd_valid[i-1];
        fwd_key[i]   <= fwd_key[i-1];
        fwd_ctr[i]   <= fwd_ctr[i-1];
      end
      fwd_valid[0] <= 1'b1;
      fwd_key[0]   <= head_key;
      fwd_ctr[0]   <= bht_next_counter(issue_counter, head.taken);
    end
  end
`else
  assign issue_counter = head.counter;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      update <= '0;
    end else if (pop) begin
      update.valid   <= 1'b1;
      update.pc      <= head.pc;
      update.taken   <= head.taken;
      update.counter <= issue_counter;
    end else begin
      update.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// tb/tb_bht_update_queue.sv - directed vector bench for bht_update_queue
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

`ifdef BHT_COUNTER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        resolve_valid;
  virt_t       resolve_pc;
  logic        resolve_taken;
  logic [1:0]  resolve_counter;
  logic        resolve_ready;
  logic        drain_en;
  bht_update_t update;

  bht_update_queue #(.SIZE(4096), .DEPTH(8), .FWD_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .resolve_valid   (resolve_valid),
    .resolve_pc      (resolve_pc),
    .resolve_taken   (resolve_taken),
    .resolve_counter (resolve_counter),
    .resolve_ready   (resolve_ready),
    .drain_en        (drain_en),
    .update          (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        tk;
    logic [1:0]  ctr;
    logic        dr;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_tk;
    logic [1:0]  e_ctr;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc, input logic tk,
                       input logic [1:0] ctr, input logic dr);
    resolve_valid   = rv;
    resolve_pc      = pc;
    resolve_taken   = tk;
    resolve_counter = ctr;
    drain_en        = dr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  vec_t        vt [15];
  logic [1:0]  c_fwd01;
  logic [1:0]  c_fwd11;
  logic [32:0] sb [$];
  logic [32:0] exp_e;
  logic [31:0] rpc;
  logic        rtk;

  initial begin
    c_fwd01 = FWD ? 2'b01 : 2'b00;
    c_fwd11 = FWD ? 2'b11 : 2'b00;
    vt[0]  = '{1'b1, 32'h8000_0004, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00};
    vt[1]  = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b1, 2'b01};
    vt[2]  = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h8000_0004, 1'b1, 2'b01};
    vt[3]  = '{1'b1, 32'h100,       1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'h8000_0004, 1'b1, 2'b01};
    vt[4]  = '{1'b1, 32'h100,       1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h100,       1'b1, 2'b00};
    vt[5]  = '{1'b1, 32'h100,       1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h100,       1'b1, c_fwd01};
    vt[6]  = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h100,       1'b1, c_fwd11};
    vt[7]  = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h100,       1'b1, c_fwd11};
    vt[8]  = '{1'b1, 32'h200,       1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h100,       1'b1, c_fwd11};
    vt[9]  = '{1'b1, 32'h204,       1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h100,       1'b1, c_fwd11};
    vt[10] = '{1'b1, 32'h200,       1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h100,       1'b1, c_fwd11};
    vt[11] = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h200,       1'b1, 2'b00};
    vt[12] = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h204,       1'b0, 2'b11};
    vt[13] = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'h200,       1'b1, c_fwd01};
    vt[14] = '{1'b0, 32'h0,         1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h200,       1'b1, c_fwd01};

    // Reset with a push presented: it must be dropped.
    rst = 1'b1;
    drive(1'b1, 32'hdead_0000, 1'b1, 2'b11, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
    chk("reset_ready", 32'(resolve_ready), 32'd1);
    chk("reset_valid", 32'(update.valid), 32'd0);
    chk("reset_pc", update.pc, 32'h0);
    chk("reset_counter", 32'(update.counter), 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rv, vt[i].pc, vt[i].tk, vt[i].ctr, vt[i].dr);
      step();
      chk($sformatf("vec%0d_ready", i), 32'(resolve_ready), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(update.valid), 32'(vt[i].e_v));
      chk($sformatf("vec%0d_pc", i), update.pc, vt[i].e_pc);
      chk($sformatf("vec%0d_taken", i), 32'(update.taken), 32'(vt[i].e_tk));
      chk($sformatf("vec%0d_counter", i), 32'(update.counter), 32'(vt[i].e_ctr));
    end

    // Fill to full with drain held off, then a refused ninth offer.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + 32'(8 * i), 1'(i & 1), 2'(i & 3), 1'b0);
      step();
      chk($sformatf("fill%0d_ready", i), 32'(resolve_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 32'h9999_0000, 1'b1, 2'b11, 1'b0);
    step();
    chk("full_ninth_ready", 32'(resolve_ready), 32'd0);
    chk("full_frozen_valid", 32'(update.valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d_valid", i), 32'(update.valid), 32'd1);
      chk($sformatf("drain%0d_pc", i), update.pc, 32'h1000 + 32'(8 * i));
      chk($sformatf("drain%0d_taken", i), 32'(update.taken), 32'(i & 1));
    end
    step();
    chk("drain_done_valid", 32'(update.valid), 32'd0);
    chk("drain_done_ready", 32'(resolve_ready), 32'd1);

    // Reset mid-operation with entries queued and an update in flight.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h3000 + 32'(8 * i), 1'b1, 2'b01, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
    step();
    chk("prerst_valid", 32'(update.valid), 32'd1);
    chk("prerst_pc", update.pc, 32'h3000);
    rst = 1'b1;
    drive(1'b1, 32'h7777_0000, 1'b1, 2'b01, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
    chk("midrst_valid", 32'(update.valid), 32'd0);
    chk("midrst_pc", update.pc, 32'h0);
    chk("midrst_ready", 32'(resolve_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("postrst%0d_valid", i), 32'(update.valid), 32'd0);
    end
    chk("postrst_ready", 32'(resolve_ready), 32'd1);

    // Sustained push+pop with random PCs: order preserved, never fills.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 2'b10, 1'b0);
      sb.push_back({1'b0, 32'h5000 + 32'(4 * i)});
      step();
    end
    for (int i = 0; i < 20; i++) begin
      rpc = $urandom & 32'hffff_fffc;
      rtk = 1'($urandom_range(0, 1));
      drive(1'b1, rpc, rtk, 2'($urandom_range(0, 3)), 1'b1);
      sb.push_back({rtk, rpc});
      step();
      exp_e = sb.pop_front();
      chk($sformatf("stream%0d_valid", i), 32'(update.valid), 32'd1);
      chk($sformatf("stream%0d_pc", i), update.pc, exp_e[31:0]);
      chk($sformatf("stream%0d_taken", i), 32'(update.taken), 32'(exp_e[32]));
      chk($sformatf("stream%0d_ready", i), 32'(resolve_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      exp_e = sb.pop_front();
      chk($sformatf("tail%0d_pc", i), update.pc, exp_e[31:0]);
      chk($sformatf("tail%0d_valid", i), 32'(update.valid), 32'd1);
    end
    step();
    chk("tail_idle_valid", 32'(update.valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
